// File: rtl/error_inject_ctrl.sv
// Error-injection sequencer: arm target, delay, pulse enable, await fault.
// Optional ERROR_INJECT_CTRL_XTARGET_CHECK_EN flags faults on other targets.
module error_inject_ctrl #(
  parameter int unsigned NumTargets = 3,
  parameter int unsigned DelayW     = 16,
  parameter int unsigned PulseW     = 8,
  parameter int unsigned TimeoutW   = 16,
  localparam int unsigned TgtW =
    (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [TgtW-1:0]       target_i,
  input  logic [DelayW-1:0]     delay_i,
  input  logic [PulseW-1:0]     pulse_len_i,
  input  logic [TimeoutW-1:0]   timeout_i,
  input  logic                  abort_i,
  input  logic [NumTargets-1:0] fault_seen_i,
  output logic [NumTargets-1:0] inject_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic                  err_o,
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
  output logic                  xtarget_o,
`endif
  output logic [7:0]            inject_cnt_o
);

  localparam int unsigned CntA =
    (DelayW > PulseW) ? DelayW : PulseW;
  localparam int unsigned CntW =
    (CntA > TimeoutW) ? CntA : TimeoutW;
  localparam logic [TgtW:0] NumT =
    (TgtW+1)'(NumTargets);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_INJECT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TgtW-1:0]       tgt_q, tgt_d;
  logic [PulseW-1:0]     plen_q, plen_d;
  logic [TimeoutW-1:0]   tlen_q, tlen_d;
  logic                  flag_q, flag_d;
  logic [NumTargets-1:0] inj_q, inj_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  tout_q, tout_d;
  logic                  err_q, err_d;
  logic [7:0]            icnt_q, icnt_d;

  logic [NumTargets-1:0] tgt_oh;
  logic [PulseW-1:0]     plen_in;
  logic                  accept;
  logic                  illegal;
  logic                  active;
  logic                  hit_now;
  logic                  hit_any;
  logic                  xany;

  assign tgt_oh  = NumTargets'(1) << tgt_q;
  assign plen_in = (pulse_len_i == '0) ?
                   PulseW'(1) : pulse_len_i;
  assign accept  = (state_q == S_IDLE) && start_i;
  assign illegal = {1'b0, target_i} >= NumT;
  assign active  = (state_q == S_INJECT) ||
                   (state_q == S_WAIT);
  assign hit_now = |(fault_seen_i & tgt_oh);
  assign hit_any = flag_q | hit_now;

`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
  logic xflag_q, xflag_d;
  logic xhit_now;

  assign xhit_now = |(fault_seen_i & ~tgt_oh);
  assign xany     = xflag_q | (active & xhit_now);
  assign xtarget_o = xflag_q;

  always_comb begin
    xflag_d = xflag_q;
    if (accept) begin
      xflag_d = 1'b0;
    end else if (active && xhit_now) begin
      xflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xflag_q <= 1'b0;
    end else begin
      xflag_q <= xflag_d;
    end
  end
`else
  assign xany = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (illegal) begin
            state_d = S_DONE;
          end else if (delay_i == '0) begin
            state_d = S_INJECT;
          end else begin
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == CntW'(1)) state_d = S_INJECT;
      end
      S_INJECT: begin
        if (cnt_q == CntW'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit_any || (cnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tgt_d  = tgt_q;
    plen_d = plen_q;
    tlen_d = tlen_q;
    flag_d = flag_q;
    pass_d = pass_q;
    tout_d = tout_q;
    err_d  = err_q;
    icnt_d = icnt_q;

    if (accept) begin
      tgt_d  = target_i;
      plen_d = plen_in;
      tlen_d = timeout_i;
      flag_d = 1'b0;
      pass_d = 1'b0;
      tout_d = 1'b0;
      err_d  = illegal;
      cnt_d  = (delay_i == '0) ?
               CntW'(plen_in) : CntW'(delay_i);
    end else if (state_q == S_DELAY &&
                 state_d == S_INJECT) begin
      cnt_d = CntW'(plen_q);
    end else if (state_q == S_INJECT &&
                 state_d == S_WAIT) begin
      cnt_d = CntW'(tlen_q);
    end else if (active || state_q == S_DELAY) begin
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    end

    if (!accept && active && hit_now) begin
      flag_d = 1'b1;
    end

    if (state_q == S_WAIT && state_d == S_DONE) begin
      pass_d = hit_any & ~xany;
      tout_d = ~hit_any;
      err_d  = err_q | xany;
    end

    inj_d  = (state_q == S_INJECT && !abort_i) ?
             tgt_oh : '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE) && !abort_i;

    if (done_d && !err_q && icnt_q != 8'hFF) begin
      icnt_d = icnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tgt_q  <= '0;
      plen_q <= '0;
      tlen_q <= '0;
      flag_q <= 1'b0;
      inj_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tout_q <= 1'b0;
      err_q  <= 1'b0;
      icnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tgt_q  <= tgt_d;
      plen_q <= plen_d;
      tlen_q <= tlen_d;
      flag_q <= flag_d;
      inj_q  <= inj_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      tout_q <= tout_d;
      err_q  <= err_d;
      icnt_q <= icnt_d;
    end
  end

  assign inject_en_o  = inj_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign timeout_o    = tout_q;
  assign err_o        = err_q;
  assign inject_cnt_o = icnt_q;

endmodule

// File: tb/tb_error_inject_ctrl.sv
// Directed bench for error_inject_ctrl.
// Vector table plus abort, reset and saturation sequences.
module tb_error_inject_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  target_i;
  logic [15:0] delay_i;
  logic [7:0]  pulse_len_i;
  logic [15:0] timeout_i;
  logic        abort_i;
  logic [2:0]  fault_seen_i;
  logic [2:0]  inject_en_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
  logic        err_o;
  logic [7:0]  inject_cnt_o;
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
  logic        xtarget_o;
`endif

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  error_inject_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .target_i     (target_i),
    .delay_i      (delay_i),
    .pulse_len_i  (pulse_len_i),
    .timeout_i    (timeout_i),
    .abort_i      (abort_i),
    .fault_seen_i (fault_seen_i),
    .inject_en_o  (inject_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o),
    .err_o        (err_o),
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
    .xtarget_o    (xtarget_o),
`endif
    .inject_cnt_o (inject_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    int         dly;
    int         pls;
    int         tmo;
    logic [2:0] fm;
    int         fat;
    logic [2:0] fm2;
    int         fat2;
    int         en_first;
    int         en_len;
    int         done_at;
    int         pass;
    int         tout;
    int         err;
    int         xt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int first;
    int len;
    int bad;
    int dat;
    logic [2:0] exp_oh;
    first = -1;
    len = 0;
    bad = 0;
    dat = -1;
    exp_oh = (v.tgt < 3) ? 3'(1 << v.tgt) : 3'b000;
    target_i    = 2'(v.tgt);
    delay_i     = 16'(v.dly);
    pulse_len_i = 8'(v.pls);
    timeout_i   = 16'(v.tmo);
    start_i     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk($sformatf("v%0d busy_k0", id), int'(busy_o), 1);
    for (int k = 0; k < 200 && dat < 0; k++) begin
      if (inject_en_o != 3'b000) begin
        if (first < 0) first = k;
        len++;
        if (inject_en_o != exp_oh) bad++;
      end
      if (done_o) dat = k;
      fault_seen_i =
        ((k == v.fat)  ? v.fm  : 3'b000) |
        ((k == v.fat2) ? v.fm2 : 3'b000);
      @(negedge clk);
    end
    fault_seen_i = 3'b000;
    if (v.err == 0 && exp_cnt < 255) exp_cnt++;
    chk($sformatf("v%0d en_first", id), first, v.en_first);
    chk($sformatf("v%0d en_len", id), len, v.en_len);
    chk($sformatf("v%0d en_value", id), bad, 0);
    chk($sformatf("v%0d done_at", id), dat, v.done_at);
    chk($sformatf("v%0d done_1cyc", id), int'(done_o), 0);
    chk($sformatf("v%0d busy_end", id), int'(busy_o), 0);
    chk($sformatf("v%0d pass", id), int'(pass_o), v.pass);
    chk($sformatf("v%0d timeout", id),
        int'(timeout_o), v.tout);
    chk($sformatf("v%0d err", id), int'(err_o), v.err);
    chk($sformatf("v%0d cnt", id),
        int'(inject_cnt_o), exp_cnt);
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
    chk($sformatf("v%0d xtarget", id), int'(xtarget_o), v.xt);
`endif
  endtask

  function automatic vec_t mk(
    int tgt, int dly, int pls, int tmo,
    logic [2:0] fm, int fat,
    logic [2:0] fm2, int fat2,
    int enf, int enl, int dn,
    int ps, int to, int er, int xt);
    vec_t v;
    v.tgt = tgt; v.dly = dly; v.pls = pls; v.tmo = tmo;
    v.fm = fm; v.fat = fat; v.fm2 = fm2; v.fat2 = fat2;
    v.en_first = enf; v.en_len = enl; v.done_at = dn;
    v.pass = ps; v.tout = to; v.err = er; v.xt = xt;
    return v;
  endfunction

  int runs;
  int seen;

  initial begin
    vecs[0] = mk(1, 4, 3, 10, 3'b010, 9, 3'b000, -1,
                 5, 3, 11, 1, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 5, 3'b000, -1, 3'b000, -1,
                 1, 1, 8, 0, 1, 0, 0);
    vecs[2] = mk(3, 1, 1, 1, 3'b000, -1, 3'b000, -1,
                 -1, 0, 1, 0, 0, 1, 0);
    vecs[3] = mk(2, 1, 2, 3, 3'b000, -1, 3'b000, -1,
                 2, 2, 8, 0, 1, 0, 0);
    vecs[4] = mk(0, 2, 4, 20, 3'b001, 3, 3'b000, -1,
                 3, 4, 8, 1, 0, 0, 0);
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
    vecs[5] = mk(1, 0, 1, 2, 3'b101, 1, 3'b000, -1,
                 1, 1, 5, 0, 1, 1, 1);
`else
    vecs[5] = mk(1, 0, 1, 2, 3'b101, 1, 3'b000, -1,
                 1, 1, 5, 0, 1, 0, 0);
`endif
    vecs[6] = mk(2, 0, 1, 2, 3'b100, 3, 3'b000, -1,
                 1, 1, 5, 1, 0, 0, 0);
    vecs[7] = mk(2, 0, 0, 0, 3'b100, 0, 3'b000, -1,
                 1, 1, 3, 1, 0, 0, 0);
    vecs[8] = mk(0, 0, 1, 0, 3'b000, -1, 3'b000, -1,
                 1, 1, 3, 0, 1, 0, 0);
`ifdef ERROR_INJECT_CTRL_XTARGET_CHECK_EN
    vecs[9] = mk(0, 0, 1, 10, 3'b100, 2, 3'b001, 4,
                 1, 1, 6, 0, 0, 1, 1);
`else
    vecs[9] = mk(0, 0, 1, 10, 3'b100, 2, 3'b001, 4,
                 1, 1, 6, 1, 0, 0, 0);
`endif

    rst_n = 1'b0;
    start_i = 1'b0;
    target_i = '0;
    delay_i = '0;
    pulse_len_i = '0;
    timeout_i = '0;
    abort_i = 1'b0;
    fault_seen_i = '0;
    repeat (2) @(negedge clk);
    chk("rst en", int'(inject_en_o), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst pass", int'(pass_o), 0);
    chk("rst timeout", int'(timeout_o), 0);
    chk("rst err", int'(err_o), 0);
    chk("rst cnt", int'(inject_cnt_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // abort on the 2nd of 5 pulse cycles
    target_i = 2'd1;
    delay_i = 16'd0;
    pulse_len_i = 8'd5;
    timeout_i = 16'd5;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("abort en_1st", int'(inject_en_o), 2);
    @(negedge clk);
    chk("abort en_2nd", int'(inject_en_o), 2);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort en", int'(inject_en_o), 0);
    chk("abort busy", int'(busy_o), 0);
    chk("abort done", int'(done_o), 0);
    chk("abort pass", int'(pass_o), 0);
    chk("abort timeout", int'(timeout_o), 0);
    chk("abort cnt", int'(inject_cnt_o), exp_cnt);
    run_vec(vecs[8], 10);

    // saturate the completed-injection counter
    seen = 0;
    fault_seen_i = 3'b100;
    target_i = 2'd2;
    delay_i = 16'd0;
    pulse_len_i = 8'd0;
    timeout_i = 16'd0;
    for (runs = 0; runs < 256; runs++) begin
      start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (done_o) begin
          seen++;
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
    end
    fault_seen_i = 3'b000;
    chk("sat runs", seen, 256);
    chk("sat cnt", int'(inject_cnt_o), 255);
    chk("sat pass", int'(pass_o), 1);

    // reset mid-injection
    target_i = 2'd2;
    delay_i = 16'd0;
    pulse_len_i = 8'd4;
    timeout_i = 16'd5;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst en_pre", int'(inject_en_o), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst en", int'(inject_en_o), 0);
    chk("midrst busy", int'(busy_o), 0);
    chk("midrst cnt", int'(inject_cnt_o), 0);
    chk("midrst pass", int'(pass_o), 0);
    @(negedge clk);
    chk("midrst en_hold", int'(inject_en_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/error_inject_ctrl.md
Name: error_inject_ctrl

Overview:
Sequencer that sits directly upstream of the per-module error-injection interfaces (counter, reset-consistency and host-grant fault hooks). It arms one selected target, waits a programmed delay, asserts that target's injection enable for a programmed pulse length, then waits for the target's fault indication and reports pass or timeout. It lets the top-level bench schedule cycle-accurate injections without per-interface timing code.

Parameters:
NumTargets, 3, number of injection interfaces driven (one enable and one fault-seen line each)
DelayW, 16, width of start-to-inject delay counter
PulseW, 8, width of injection pulse-length counter
TimeoutW, 16, width of fault-response timeout counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  launch request; sampled only in IDLE
target_i  input  $clog2(NumTargets)  target index, latched on start
delay_i  input  DelayW  cycles between start and first inject cycle, latched on start
pulse_len_i  input  PulseW  inject cycles, latched on start; 0 treated as 1
timeout_i  input  TimeoutW  cycles allowed for fault response after pulse, latched on start
abort_i  input  1  cancel in any state
fault_seen_i  input  NumTargets  per-target fault/alert observed
inject_en_o  output  NumTargets  one-hot registered injection enable
busy_o  output  1  high in any state other than IDLE
done_o  output  1  single-cycle completion pulse
pass_o  output  1  target fault observed; held until next accepted start
timeout_o  output  1  no fault within window; held until next accepted start
err_o  output  1  illegal target index; held until next accepted start
inject_cnt_o  output  8  completed injections, saturating at 255

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous, active-low. All outputs 0 in reset; FSM in IDLE.
- States: IDLE, DELAY, INJECT, WAIT, DONE. All state registers and outputs are registered.
- IDLE: start_i=1 on edge T latches configuration and clears pass_o, timeout_o, err_o and the sticky fault flag.
  - target_i >= NumTargets: go to DONE, err_o=1.
  - delay_i=0: go to INJECT.
  - otherwise: go to DELAY.
- DELAY: count down delay_i cycles, then go to INJECT. inject_en_o[target] is high from edge T+1+delay_i.
- INJECT: inject_en_o[target]=1 for max(pulse_len_i,1) cycles, then 0 and go to WAIT. Only the latched target bit is ever set.
- Sticky fault flag: set by fault_seen_i[target]=1 in INJECT or WAIT.
- WAIT: timeout counter starts at timeout_i.
  - Sticky flag set (including a fault seen during INJECT): go to DONE with pass_o=1.
  - Counter reaches 0 with no fault: go to DONE with timeout_o=1.
  - timeout_i=0 with flag clear on WAIT entry: immediate timeout.
  - Fault and counter expiry on the same cycle: pass wins.
- DONE: done_o=1 for exactly one cycle. Increment inject_cnt_o unless err_o=1. Return to IDLE.
- start_i while busy_o=1: ignored, not queued.
- abort_i=1 in any non-IDLE state: next edge goes to IDLE, inject_en_o cleared, no done_o, pass/timeout/err unchanged, counter unchanged. Abort has priority over every other transition.
- Reset asserted mid-operation: all outputs clear immediately (async). inject_en_o must never glitch high through reset.
- fault_seen_i bits for non-selected targets are ignored (see optional feature).

Optional Feature:
- Macro: ERROR_INJECT_CTRL_XTARGET_CHECK_EN.
- Defined: any fault_seen_i bit other than the latched target during INJECT or WAIT sets a sticky xtarget flag. In DONE that flag forces err_o=1 and pass_o=0. Adds output port xtarget_o (1 bit), reset 0, held until next accepted start.
- Undefined: non-target bits are ignored and port xtarget_o is absent.

Test Plan:
- target=1, delay=4, pulse=3, timeout=10, start at edge T; fault_seen_i[1] pulses at T+9 -> inject_en_o=3'b010 on edges T+5..T+7; pass_o=1; done_o at T+11; inject_cnt_o=1.
- target=0, delay=0, pulse=0, timeout=5, no fault -> inject_en_o=3'b001 for exactly 1 cycle at T+1; timeout_o=1; done_o 6 cycles after pulse ends.
- target=3 (illegal) -> no inject_en_o activity; err_o=1; done_o at T+1; inject_cnt_o unchanged.
- abort_i during INJECT, 2nd of 5 pulse cycles -> inject_en_o=0 next edge; busy_o=0; no done_o; new start accepted the following cycle.
- Fault on target 2 during INJECT, timeout=0 -> pass_o=1 (sticky flag beats immediate timeout); 256 passes leave inject_cnt_o at 255.
- With ERROR_INJECT_CTRL_XTARGET_CHECK_EN: target=0, fault_seen_i=3'b100 in WAIT then 3'b001 -> xtarget_o=1, err_o=1, pass_o=0.
